// File: rtl/tick_sched_pkg.sv
// Shared types and divisor clamping helpers for the tick scheduler.
package tick_sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        PEND = 2'd2
    } state_t;

    localparam int FAST_MIN = 2;
    localparam int SLOW_MIN = 1;

    // A fast divisor below 2 could never produce a gap between strobes.
    function automatic logic [63:0] clamp_fast(input logic [63:0] d);
        return (d < 64'(FAST_MIN)) ? 64'(FAST_MIN) : d;
    endfunction

    function automatic logic [63:0] clamp_slow(input logic [63:0] d);
        return (d < 64'(SLOW_MIN)) ? 64'(SLOW_MIN) : d;
    endfunction

endpackage

// File: rtl/tick_scheduler_if.sv
// Divisor reload handshake between a configuring master and the tick scheduler.
interface tick_scheduler_if #(
    parameter int FAST_W = 26,
    parameter int SLOW_W = 32
) ();

    logic              cfg_valid;
    logic              cfg_ready;
    logic [FAST_W-1:0] cfg_fast_div;
    logic [SLOW_W-1:0] cfg_slow_div;

    modport master (
        output cfg_valid,
        output cfg_fast_div,
        output cfg_slow_div,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid,
        input  cfg_fast_div,
        input  cfg_slow_div,
        output cfg_ready
    );

endinterface

// File: rtl/tick_scheduler_mod_counter.sv
// Modulo counter holding its own active divisor; wrap flags the last count of a period.
module mod_counter #(
    parameter int             W         = 8,
    parameter logic [W-1:0]   RESET_DIV = W'(2)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         clr,
    input  logic         load,
    input  logic [W-1:0] load_div,
    output logic         wrap,
    output logic [W-1:0] count
);

    logic [W-1:0] div;

    // Wrap always reflects the divisor in force before any load on the same edge.
    assign wrap = en && !clr && (count == div - W'(1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
            div   <= RESET_DIV;
        end else if (clr) begin
            count <= '0;
        end else if (load) begin
            count <= '0;
            div   <= load_div;
        end else if (wrap) begin
            count <= '0;
        end else if (en) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/tick_scheduler.sv
// Programmable fast/slow tick generator with glitch-free runtime divisor reload.
module tick_scheduler
    import tick_sched_pkg::*;
#(
    parameter int          FAST_W   = 26,
    parameter int          SLOW_W   = 32,
    parameter int unsigned FAST_DIV = 5001,
    parameter int unsigned SLOW_DIV = 20001
) (
    input  logic                 clk_sys,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 clr,
    tick_scheduler_if.slave      cfg,
    output logic                 fast_tick,
    output logic                 slow_tick,
    output logic                 fast_sq,
    output logic                 slow_sq
);

    state_t            state;
    state_t            state_next;
    logic              accept;
    logic              apply;
    logic              fast_wrap;
    logic              slow_wrap;
    logic [FAST_W-1:0] shadow_fast;
    logic [SLOW_W-1:0] shadow_slow;
    logic [FAST_W-1:0] fast_cnt_unused;
    logic [SLOW_W-1:0] slow_cnt_unused;

    assign cfg.cfg_ready = (state != PEND);
    assign accept        = cfg.cfg_valid && cfg.cfg_ready;

    mod_counter #(.W(FAST_W), .RESET_DIV(FAST_W'(FAST_DIV))) u_fast (
        .clk      (clk_sys),
        .rst_n    (rst_n),
        .en       (en),
        .clr      (clr),
        .load     (apply),
        .load_div (shadow_fast),
        .wrap     (fast_wrap),
        .count    (fast_cnt_unused)
    );

    // The slow counter advances once per fast period.
    mod_counter #(.W(SLOW_W), .RESET_DIV(SLOW_W'(SLOW_DIV))) u_slow (
        .clk      (clk_sys),
        .rst_n    (rst_n),
        .en       (fast_wrap),
        .clr      (clr),
        .load     (apply),
        .load_div (shadow_slow),
        .wrap     (slow_wrap),
        .count    (slow_cnt_unused)
    );

    always_ff @(posedge clk_sys) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A pending pair lands on the next fast wrap, or at once if counting stops.
    always_comb begin
        state_next = state;
        apply      = 1'b0;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    state_next = PEND;
                end else if (en) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (accept) begin
                    state_next = PEND;
                end else if (!en) begin
                    state_next = IDLE;
                end
            end
            PEND: begin
                if (!clr && (!en || fast_wrap)) begin
                    apply      = 1'b1;
                    state_next = en ? RUN : IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (!rst_n) begin
            shadow_fast <= FAST_W'(FAST_DIV);
            shadow_slow <= SLOW_W'(SLOW_DIV);
        end else if (accept) begin
            shadow_fast <= FAST_W'(clamp_fast(64'(cfg.cfg_fast_div)));
            shadow_slow <= SLOW_W'(clamp_slow(64'(cfg.cfg_slow_div)));
        end
    end

    always_ff @(posedge clk_sys) begin
        if (!rst_n || clr) begin
            fast_tick <= 1'b0;
            slow_tick <= 1'b0;
            fast_sq   <= 1'b0;
            slow_sq   <= 1'b0;
        end else begin
            fast_tick <= fast_wrap;
            slow_tick <= slow_wrap;
            fast_sq   <= fast_sq ^ fast_wrap;
            slow_sq   <= slow_sq ^ slow_wrap;
        end
    end

endmodule

// File: tb/tb_tick_scheduler.sv
// Directed bench for tick_scheduler, checked against a per-edge behavioural model.
module tb_tick_scheduler;

    logic clk_sys = 1'b0;
    logic rst_n;
    logic en;
    logic clr;
    logic fast_tick;
    logic slow_tick;
    logic fast_sq;
    logic slow_sq;

    int tests_run    = 0;
    int tests_failed = 0;

    tick_scheduler_if #(.FAST_W(26), .SLOW_W(32)) cfg_bus ();

    tick_scheduler #(
        .FAST_W   (26),
        .SLOW_W   (32),
        .FAST_DIV (4),
        .SLOW_DIV (3)
    ) dut (
        .clk_sys   (clk_sys),
        .rst_n     (rst_n),
        .en        (en),
        .clr       (clr),
        .cfg       (cfg_bus),
        .fast_tick (fast_tick),
        .slow_tick (slow_tick),
        .fast_sq   (fast_sq),
        .slow_sq   (slow_sq)
    );

    always #5 clk_sys = ~clk_sys;

    // Model state: counts, divisors in force, pending pair and expected outputs.
    longint m_fcnt, m_scnt, m_fdiv, m_sdiv, m_pf, m_ps;
    bit     m_pend, m_ft, m_st, m_fsq, m_ssq, m_ready;
    bit     model_on = 1'b0;

    task automatic check_output(input string name, input logic [63:0] actual,
                                input logic [63:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    always @(posedge clk_sys) begin
        bit fw, sw, acc;
        if (!rst_n) begin
            m_fcnt = 0; m_scnt = 0; m_fdiv = 4; m_sdiv = 3;
            m_pend = 0; m_ft = 0; m_st = 0; m_fsq = 0; m_ssq = 0; m_ready = 1;
            model_on = 1'b1;
        end else if (model_on) begin
            acc = cfg_bus.cfg_valid && m_ready;
            if (clr) begin
                m_fcnt = 0; m_scnt = 0; m_ft = 0; m_st = 0; m_fsq = 0; m_ssq = 0;
            end else begin
                fw = en && (m_fcnt == m_fdiv - 1);
                sw = fw && (m_scnt == m_sdiv - 1);
                m_ft = fw;
                m_st = sw;
                if (fw) m_fsq = !m_fsq;
                if (sw) m_ssq = !m_ssq;
                if (m_pend && (!en || fw)) begin
                    m_fdiv = m_pf; m_sdiv = m_ps; m_fcnt = 0; m_scnt = 0; m_pend = 0;
                end else if (fw) begin
                    m_fcnt = 0;
                    m_scnt = sw ? 0 : m_scnt + 1;
                end else if (en) begin
                    m_fcnt = m_fcnt + 1;
                end
            end
            if (acc) begin
                m_pend = 1;
                m_pf = (cfg_bus.cfg_fast_div < 2) ? 2 : longint'(cfg_bus.cfg_fast_div);
                m_ps = (cfg_bus.cfg_slow_div == 0) ? 1 : longint'(cfg_bus.cfg_slow_div);
            end
            m_ready = !m_pend;
        end
    end

    always @(negedge clk_sys) begin
        if (model_on) begin
            check_output("model_fast_tick", 64'(fast_tick), 64'(m_ft));
            check_output("model_slow_tick", 64'(slow_tick), 64'(m_st));
            check_output("model_fast_sq", 64'(fast_sq), 64'(m_fsq));
            check_output("model_slow_sq", 64'(slow_sq), 64'(m_ssq));
            check_output("model_cfg_ready", 64'(cfg_bus.cfg_ready), 64'(m_ready));
        end
    end

    task automatic apply_stimulus(input logic r, input logic e, input logic c, input logic v,
                                  input logic [25:0] fd, input logic [31:0] sd);
        rst_n                = r;
        en                   = e;
        clr                  = c;
        cfg_bus.cfg_valid    = v;
        cfg_bus.cfg_fast_div = fd;
        cfg_bus.cfg_slow_div = sd;
    endtask

    task automatic step_cycles(input int n);
        repeat (n) @(posedge clk_sys);
        #1;
    endtask

    bit ft_h [0:15];
    bit st_h [0:15];
    bit fs_h [0:15];

    task automatic record(input int c);
        step_cycles(1);
        ft_h[c] = fast_tick;
        st_h[c] = slow_tick;
        fs_h[c] = fast_sq;
    endtask

    initial begin
        int  n;
        bit  seen;
        bit  any_tick;

        apply_stimulus(0, 0, 0, 0, 0, 0);
        step_cycles(2);
        check_output("reset_fast_tick", 64'(fast_tick), 0);
        check_output("reset_slow_tick", 64'(slow_tick), 0);
        check_output("reset_fast_sq", 64'(fast_sq), 0);
        check_output("reset_slow_sq", 64'(slow_sq), 0);
        check_output("reset_cfg_ready", 64'(cfg_bus.cfg_ready), 1);

        // Free running from reset release: fast every 4, slow every 12.
        apply_stimulus(1, 1, 0, 0, 0, 0);
        for (int c = 1; c <= 12; c++) record(c);
        check_output("s1_ft_c3", 64'(ft_h[3]), 0);
        check_output("s1_ft_c4", 64'(ft_h[4]), 1);
        check_output("s1_ft_c7", 64'(ft_h[7]), 0);
        check_output("s1_ft_c8", 64'(ft_h[8]), 1);
        check_output("s1_ft_c12", 64'(ft_h[12]), 1);
        check_output("s1_st_c8", 64'(st_h[8]), 0);
        check_output("s1_st_c12", 64'(st_h[12]), 1);
        check_output("s1_fsq_c4", 64'(fs_h[4]), 1);
        check_output("s1_fsq_c5", 64'(fs_h[5]), 1);
        check_output("s1_fsq_c8", 64'(fs_h[8]), 0);

        // Hold at fast_cnt=2, then resume.
        step_cycles(2);
        apply_stimulus(1, 0, 0, 0, 0, 0);
        any_tick = 0;
        for (int i = 0; i < 5; i++) begin
            step_cycles(1);
            any_tick |= fast_tick | slow_tick;
        end
        check_output("s2_no_tick_while_held", 64'(any_tick), 0);
        apply_stimulus(1, 1, 0, 0, 0, 0);
        step_cycles(1);
        check_output("s2_ft_resume_1", 64'(fast_tick), 0);
        step_cycles(1);
        check_output("s2_ft_resume_2", 64'(fast_tick), 1);

        // Reload to 6 while running at fast_cnt=1.
        step_cycles(1);
        apply_stimulus(1, 1, 0, 1, 6, 3);
        step_cycles(1);
        apply_stimulus(1, 1, 0, 0, 0, 0);
        check_output("s3_ready_low_after_accept", 64'(cfg_bus.cfg_ready), 0);
        step_cycles(1);
        check_output("s3_ready_low_before_wrap", 64'(cfg_bus.cfg_ready), 0);
        step_cycles(1);
        check_output("s3_ft_old_wrap", 64'(fast_tick), 1);
        check_output("s3_ready_after_wrap", 64'(cfg_bus.cfg_ready), 1);
        n = 0;
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            step_cycles(1);
            n++;
            seen = fast_tick;
        end
        check_output("s3_new_period", 64'(seen ? n : 0), 6);

        // Out-of-range pair while idle clamps to 2/1.
        apply_stimulus(1, 0, 0, 1, 0, 0);
        step_cycles(1);
        apply_stimulus(1, 0, 0, 0, 0, 0);
        check_output("s4_ready_pend", 64'(cfg_bus.cfg_ready), 0);
        step_cycles(1);
        check_output("s4_ready_applied", 64'(cfg_bus.cfg_ready), 1);
        apply_stimulus(1, 1, 0, 0, 0, 0);
        for (int c = 1; c <= 6; c++) record(c);
        check_output("s4_ft_c1", 64'(ft_h[1]), 0);
        check_output("s4_ft_c2", 64'(ft_h[2]), 1);
        check_output("s4_ft_c3", 64'(ft_h[3]), 0);
        check_output("s4_ft_c4", 64'(ft_h[4]), 1);
        check_output("s4_st_c2", 64'(st_h[2]), 1);
        check_output("s4_st_c4", 64'(st_h[4]), 1);

        // Reset while a pair is pending discards it.
        apply_stimulus(1, 1, 0, 1, 6, 3);
        step_cycles(1);
        apply_stimulus(1, 1, 0, 0, 0, 0);
        check_output("s5_ready_pend", 64'(cfg_bus.cfg_ready), 0);
        apply_stimulus(0, 0, 0, 0, 0, 0);
        step_cycles(1);
        check_output("s5_reset_ready", 64'(cfg_bus.cfg_ready), 1);
        check_output("s5_reset_fast_sq", 64'(fast_sq), 0);
        apply_stimulus(1, 1, 0, 0, 0, 0);
        for (int c = 1; c <= 6; c++) record(c);
        check_output("s5_ft_c3", 64'(ft_h[3]), 0);
        check_output("s5_ft_c4", 64'(ft_h[4]), 1);
        check_output("s5_fsq_c6", 64'(fs_h[6]), 1);

        // Clear on edge 7 restarts the period without touching the divisor.
        apply_stimulus(1, 1, 1, 0, 0, 0);
        step_cycles(1);
        check_output("s6_clr_fast_sq", 64'(fast_sq), 0);
        check_output("s6_clr_fast_tick", 64'(fast_tick), 0);
        apply_stimulus(1, 1, 0, 0, 0, 0);
        for (int c = 8; c <= 15; c++) record(c);
        check_output("s6_ft_c10", 64'(ft_h[10]), 0);
        check_output("s6_ft_c11", 64'(ft_h[11]), 1);
        check_output("s6_ft_c14", 64'(ft_h[14]), 0);
        check_output("s6_ft_c15", 64'(ft_h[15]), 1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
